// File: rtl/uart_pkg.sv
// Shared UART constants: default oversample ratio, divisor widths and reset divisor.
package uart_pkg;

  localparam int OSR_DEF          = 16;
  localparam int DIV_INT_W_DEF    = 16;
  localparam int DIV_FRAC_W_DEF   = 4;
  localparam int RST_DIV_INT_DEF  = 16;
  localparam int RST_DIV_FRAC_DEF = 0;

  typedef struct packed {
    logic [DIV_INT_W_DEF-1:0]  div_int;
    logic [DIV_FRAC_W_DEF-1:0] div_frac;
  } baud_div_t;

  // An integer divisor below 2 cannot produce a distinct tick cycle.
  function automatic logic div_int_ok(input logic [31:0] v);
    return v >= 32'd2;
  endfunction

endpackage

// File: rtl/uart_baud_frac_acc.sv
// Fractional period counter: one os tick every div_int clocks, stretched by one
// clock after each fractional-accumulator carry.
module uart_baud_frac_acc
  import uart_pkg::*;
#(
  parameter int INT_WIDTH  = DIV_INT_W_DEF,
  parameter int FRAC_WIDTH = DIV_FRAC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  acc_clr,
  input  logic [INT_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  output logic                  fire,
  output logic                  os_tick
);

  logic [INT_WIDTH:0]    cnt_q, cnt_d, limit;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic                  carry_q, carry_d;
  logic                  os_tick_q, os_tick_d;

  always_comb begin
    limit     = {1'b0, div_int} + {{INT_WIDTH{1'b0}}, carry_q};
    fire      = en && (cnt_q == (limit - {{INT_WIDTH{1'b0}}, 1'b1}));
    cnt_d     = cnt_q + {{INT_WIDTH{1'b0}}, 1'b1};
    acc_d     = acc_q;
    carry_d   = carry_q;
    os_tick_d = 1'b0;
    if (!en) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (fire) begin
      cnt_d              = '0;
      os_tick_d          = 1'b1;
      {carry_d, acc_d}   = {1'b0, acc_q} + {1'b0, div_frac};
    end
    // A newly applied divisor starts from a clean fractional phase.
    if (acc_clr) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      os_tick_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      os_tick_q <= os_tick_d;
    end
  end

  assign os_tick = os_tick_q;

endmodule

// File: rtl/uart_baud_gen.sv
// Fractional-divisor UART baud generator: os tick, bit tick every OSR os ticks,
// decoded baud clock level, and a divisor update applied on bit boundaries.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int INT_WIDTH    = DIV_INT_W_DEF,
  parameter int FRAC_WIDTH   = DIV_FRAC_W_DEF,
  parameter int OSR          = OSR_DEF,
  parameter int RST_DIV_INT  = RST_DIV_INT_DEF,
  parameter int RST_DIV_FRAC = RST_DIV_FRAC_DEF
) (
  input  logic                  i_baud_gen_clk,
  input  logic                  i_baud_gen_rst,
  input  logic                  i_baud_gen_en,
  input  logic                  i_baud_gen_cfg_valid,
  input  logic [INT_WIDTH-1:0]  i_baud_gen_cfg_int,
  input  logic [FRAC_WIDTH-1:0] i_baud_gen_cfg_frac,
  output logic                  o_baud_gen_cfg_ready,
  output logic                  o_baud_gen_cfg_err,
  output logic                  o_baud_gen_os_tick,
  output logic                  o_baud_gen_bit_tick,
  output logic                  o_baud_gen_baud_clk
);

  localparam int                OSR_W   = $clog2(OSR);
  localparam logic [OSR_W-1:0]  OSR_MAX = OSR_W'(OSR - 1);

  logic [INT_WIDTH-1:0]  div_int_q, div_int_d, pend_int_q, pend_int_d;
  logic [FRAC_WIDTH-1:0] div_frac_q, div_frac_d, pend_frac_q, pend_frac_d;
  logic                  pend_q, pend_d;
  logic [OSR_W-1:0]      os_cnt_q, os_cnt_d;
  logic                  bit_tick_q, bit_tick_d;
  logic                  baud_clk_q, baud_clk_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  os_fire, os_tick, bit_fire, apply, cfg_acc, cfg_ok;

  uart_baud_frac_acc #(
    .INT_WIDTH  (INT_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_frac_acc (
    .clk      (i_baud_gen_clk),
    .rst      (i_baud_gen_rst),
    .en       (i_baud_gen_en),
    .acc_clr  (apply),
    .div_int  (div_int_q),
    .div_frac (div_frac_q),
    .fire     (os_fire),
    .os_tick  (os_tick)
  );

  always_comb begin
    cfg_acc  = i_baud_gen_cfg_valid && !pend_q;
    cfg_ok   = div_int_ok(32'(i_baud_gen_cfg_int));
    bit_fire = os_fire && (os_cnt_q == OSR_MAX);
    // pend_q is still clear on the acceptance edge, so a config accepted on a
    // bit edge naturally waits for the following boundary.
    apply    = pend_q && (!i_baud_gen_en || bit_fire);

    os_cnt_d = os_cnt_q;
    if (!i_baud_gen_en)  os_cnt_d = '0;
    else if (os_fire)    os_cnt_d = os_cnt_q + OSR_W'(1);
    bit_tick_d = bit_fire;
    baud_clk_d = os_cnt_d[OSR_W-1];

    div_int_d   = div_int_q;
    div_frac_d  = div_frac_q;
    pend_d      = pend_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    cfg_err_d   = cfg_acc && !cfg_ok;
    if (apply) begin
      div_int_d  = pend_int_q;
      div_frac_d = pend_frac_q;
      pend_d     = 1'b0;
    end
    if (cfg_acc && cfg_ok) begin
      pend_d      = 1'b1;
      pend_int_d  = i_baud_gen_cfg_int;
      pend_frac_d = i_baud_gen_cfg_frac;
    end
  end

  always_ff @(posedge i_baud_gen_clk) begin
    if (i_baud_gen_rst) begin
      div_int_q   <= INT_WIDTH'(RST_DIV_INT);
      div_frac_q  <= FRAC_WIDTH'(RST_DIV_FRAC);
      pend_q      <= 1'b0;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      os_cnt_q    <= '0;
      bit_tick_q  <= 1'b0;
      baud_clk_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      div_int_q   <= div_int_d;
      div_frac_q  <= div_frac_d;
      pend_q      <= pend_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      os_cnt_q    <= os_cnt_d;
      bit_tick_q  <= bit_tick_d;
      baud_clk_q  <= baud_clk_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign o_baud_gen_cfg_ready = !pend_q;
  assign o_baud_gen_cfg_err   = cfg_err_q;
  assign o_baud_gen_os_tick   = os_tick;
  assign o_baud_gen_bit_tick  = bit_tick_q;
  assign o_baud_gen_baud_clk  = baud_clk_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: period-level reference model feeds a per-cycle
// expectation queue; a negedge monitor pops and compares.
module tb_uart_baud_gen;

  localparam int IW = 8, FW = 4, OSR = 4, RDI = 16, RDF = 0;

  logic          clk = 1'b0, rst = 1'b1, en = 1'b0, cv = 1'b0;
  logic [IW-1:0] ci = '0;
  logic [FW-1:0] cf = '0;
  logic          ready, err, os, bt, baud;

  int n_checks = 0, n_fail = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_e;

  // reference model state: countdown to next tick, fractional error, phase
  int m_int, m_frac, m_rem, m_e, m_ph, p_int, p_frac;
  bit m_run, m_pend, m_os, m_bt, m_baud, m_err, acc_now, fire_bit, apply;

  always #5 clk = ~clk;

  uart_baud_gen #(
    .INT_WIDTH(IW), .FRAC_WIDTH(FW), .OSR(OSR), .RST_DIV_INT(RDI), .RST_DIV_FRAC(RDF)
  ) dut (
    .i_baud_gen_clk       (clk),
    .i_baud_gen_rst       (rst),
    .i_baud_gen_en        (en),
    .i_baud_gen_cfg_valid (cv),
    .i_baud_gen_cfg_int   (ci),
    .i_baud_gen_cfg_frac  (cf),
    .o_baud_gen_cfg_ready (ready),
    .o_baud_gen_cfg_err   (err),
    .o_baud_gen_os_tick   (os),
    .o_baud_gen_bit_tick  (bt),
    .o_baud_gen_baud_clk  (baud)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model, evaluated on every rising edge with the sampled inputs.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_int = RDI; m_frac = RDF; m_run = 0; m_pend = 0; m_e = 0; m_ph = 0; m_rem = 0;
      m_os = 0; m_bt = 0; m_baud = 0; m_err = 0;
    end else begin
      acc_now = cv && !m_pend;
      m_os = 0; m_bt = 0; m_err = 0; fire_bit = 0;
      if (!en) begin
        m_run = 0; m_e = 0; m_ph = 0;
      end else begin
        if (!m_run) begin m_run = 1; m_rem = m_int; end
        m_rem--;
        if (m_rem == 0) begin
          m_os = 1; m_bt = (m_ph == OSR - 1); fire_bit = m_bt;
          m_ph = (m_ph + 1) % OSR;
          m_e += m_frac;
          m_rem = m_int + (m_e >> FW);
          m_e = m_e % (1 << FW);
        end
      end
      m_baud = en && (m_ph >= OSR / 2);
      apply = m_pend && (!en || fire_bit);
      if (apply) begin
        m_int = p_int; m_frac = p_frac; m_pend = 0; m_e = 0; m_rem = m_int;
      end
      if (acc_now) begin
        if (int'(ci) < 2) m_err = 1;
        else begin m_pend = 1; p_int = int'(ci); p_frac = int'(cf); end
      end
    end
    exp_q.push_back({m_os, m_bt, m_baud, !m_pend, m_err});
  end

  // Monitor: compare every DUT output cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("outs{os,bit,baud,rdy,err}", int'({os, bt, baud, ready, err}), int'(mon_e));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (!ready && t < 2000) begin step(); t++; end
    check(name, int'(ready), 1);
  endtask

  task automatic offer(input int i, input int f);
    wait_ready("offer_wait_ready");
    cv = 1'b1; ci = IW'(i); cf = FW'(f);
    step();
    cv = 1'b0;
  endtask

  task automatic offer_bad(input int i);
    offer(i, 5);
    check("cfg_err_pulse", int'(err), 1);
    check("cfg_err_ready", int'(ready), 1);
    step();
    check("cfg_err_once", int'(err), 0);
  endtask

  task automatic win(input int n, output int nos, output int nbt, output int nbd);
    nos = 0; nbt = 0; nbd = 0;
    repeat (n) begin
      @(negedge clk);
      nos += int'(os); nbt += int'(bt); nbd += int'(baud);
    end
  endtask

  task automatic ticks_until_os(output int n);
    n = 0;
    do begin step(); n++; end while (!os && n < 500);
  endtask

  task automatic bits_until_ready(output int nb);
    int t = 0;
    nb = int'(bt);
    while (!ready && t < 500) begin step(); nb += int'(bt); t++; end
  endtask

  initial begin
    int a, b, c, n, t;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_quiet", int'({os, bt, baud, err}), 0);

    // int=4 frac=0 loaded while disabled, then run
    offer(4, 0);
    step();
    en = 1'b1;
    repeat (10) step();
    win(16, a, b, c);
    check("int4_os_per16", a, 4);
    check("int4_bit_per16", b, 1);
    check("int4_baud_hi_per16", c, 8);

    // 3 + 8/16 average period: 2 ticks per 7 clocks
    offer(3, 8);
    wait_ready("apply_3p5");
    repeat (8) step();
    win(28, a, b, c);
    check("frac_os_per28", a, 8);
    win(56, a, b, c);
    check("frac_os_per56", a, 16);

    offer_bad(1);
    offer_bad(0);

    // accept at os phase 1: applied at the upcoming bit boundary
    offer(4, 0);
    wait_ready("apply_int4");
    repeat (5) step();
    t = 0;
    while (!(os && !bt && !baud) && t < 200) begin step(); t++; end
    check("find_phase1", int'(os && !bt && !baud), 1);
    cv = 1'b1; ci = IW'(6); cf = '0;
    step();
    cv = 1'b0;
    bits_until_ready(n);
    check("bits_to_apply_ph1", n, 1);
    ticks_until_os(n);
    check("period_after_apply6", n, 6);

    // accept on the edge that produces a bit tick: applied one bit later
    t = 0;
    while (!(m_run && en && m_rem == 1 && m_ph == OSR - 1) && t < 200) begin step(); t++; end
    cv = 1'b1; ci = IW'(4); cf = '0;
    step();
    cv = 1'b0;
    check("coincident_bit", int'(bt), 1);
    bits_until_ready(n);
    check("bits_to_apply_coinc", n, 2);

    // disable mid-period, then re-enable
    repeat (2) step();
    en = 1'b0;
    repeat (6) step();
    check("dis_quiet", int'({os, bt, baud}), 0);
    en = 1'b1;
    ticks_until_os(n);
    check("reen_latency", n, 4);
    check("reen_phase_restart", int'({bt, baud}), 0);

    // reset with a pending config
    repeat (3) step();
    offer(6, 3);
    check("pend_ready_low", int'(ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_ready", int'(ready), 1);
    check("rst_mid_quiet", int'({os, bt, baud, err}), 0);
    ticks_until_os(n);
    check("rst_latency", n, RDI);
    ticks_until_os(n);
    check("rst_period", n, RDI);

    // randomized traffic
    repeat (3000) begin
      step();
      rst = ($urandom_range(0, 999) < 3);
      if (en) en = ($urandom_range(0, 199) != 0);
      else    en = ($urandom_range(0, 19) == 0);
      cv = ($urandom_range(0, 9) == 0);
      ci = IW'($urandom_range(0, 9));
      cf = FW'($urandom_range(0, 15));
    end
    cv = 1'b0; rst = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
